// File: rtl/bram_stream_loader.sv
// Port-side controller for a synchronous-read block RAM: streams words in
// (LOAD) to consecutive addresses from 0, or streams RAM contents out (DUMP).
module bram_stream_loader #(
  parameter int unsigned DATA_W = 20,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              dump_start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_di,
  input  logic [DATA_W-1:0] ram_do,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, LOAD, RD, CAP, HOLD, FIN} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr;

  // Write strobe follows s_valid in the same cycle so no accepted word is delayed.
  assign ram_we   = (state == LOAD) && s_valid;
  assign ram_addr = addr;
  assign ram_di   = s_data;

  // Status outputs are registered alongside the state transition that implies them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr    <= '0;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          addr <= '0;
          if (load_start) begin
            state   <= LOAD;
            s_ready <= 1'b1;
            busy    <= 1'b1;
          end else if (dump_start) begin
            state <= RD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (s_valid) begin
            if (addr == LAST) begin
              state   <= FIN;
              s_ready <= 1'b0;
              done    <= 1'b1;
            end else begin
              addr <= addr + ADDR_W'(1);
            end
          end
        end
        RD: state <= CAP;
        CAP: begin
          m_data  <= ram_do;
          m_valid <= 1'b1;
          state   <= HOLD;
        end
        HOLD: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            if (addr == LAST) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              addr  <= addr + ADDR_W'(1);
              state <= RD;
            end
          end
        end
        FIN: begin
          state <= IDLE;
          addr  <= '0;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          addr    <= '0;
          s_ready <= 1'b0;
          m_valid <= 1'b0;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_stream_loader.sv
// Bench for bram_stream_loader: directed load/dump sequences against a RAM
// image model, with a per-cycle compare process and literal spot checks.
module tb_bram_stream_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start, dump_start;
  logic        s_valid;
  logic [19:0] s_data;
  logic        s_ready;
  logic        m_valid;
  logic [19:0] m_data;
  logic        m_ready;
  logic        ram_we;
  logic [5:0]  ram_addr;
  logic [19:0] ram_di;
  logic [19:0] ram_do;
  logic        busy, done;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned we_cnt = 0;
  logic [19:0] mem [64];
  logic [19:0] cap [64];

  bram_stream_loader #(.DATA_W(20), .ADDR_W(6), .DEPTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .dump_start(dump_start),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(ram_do),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Single-port RAM, read-first on a same-address write.
  initial for (int i = 0; i < 64; i++) mem[i] <= 20'hF0000 | 20'(i);
  always @(posedge clk) begin
    ram_do <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_di;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Model: image of RAM contents plus counts of words moved in the current operation.
  initial begin
    logic [19:0] img [64];
    int unsigned ld_cnt, dp_idx;
    for (int i = 0; i < 64; i++) img[i] = 20'hF0000 | 20'(i);
    ld_cnt = 0;
    dp_idx = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ld_cnt = 0;
        dp_idx = 0;
      end else begin
        check("ram_we", 32'(ram_we), 32'(s_valid && s_ready));
        if (s_valid && s_ready) begin
          check("wr_addr", 32'(ram_addr), ld_cnt);
          check("wr_data", 32'(ram_di), 32'(s_data));
          if (ld_cnt < 64) img[ld_cnt] = s_data;
          ld_cnt++;
          we_cnt++;
        end
        if (m_valid) begin
          check("m_data", 32'(m_data), (dp_idx < 64) ? 32'(img[dp_idx]) : 32'hDEAD);
          if (m_ready) dp_idx++;
        end
        if (done) begin
          check("done_busy", 32'(busy), 32'd1);
          check("done_count", 32'(ld_cnt == 64 || dp_idx == 64), 32'd1);
          ld_cnt = 0;
          dp_idx = 0;
        end
        if (!busy) check("idle_outs", {28'd0, s_ready, m_valid, ram_we, done}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [19:0] base, input int unsigned period,
                         input int unsigned n, input bit both);
    int unsigned i, cyc;
    bit acc;
    load_start = 1'b1;
    dump_start = both;
    tick();
    load_start = 1'b0;
    dump_start = 1'b0;
    check("load_entry_ready", 32'(s_ready), 32'd1);
    check("load_entry_busy", 32'(busy), 32'd1);
    i = 0;
    cyc = 0;
    while (i < n && cyc < 4000) begin
      s_valid = ((cyc % period) == 0);
      s_data = base + 20'(i);
      dump_start = (cyc == 3);
      acc = s_valid && s_ready;
      tick();
      if (acc) i++;
      cyc++;
    end
    s_valid = 1'b0;
    dump_start = 1'b0;
    check("load_budget", 32'(cyc < 4000), 32'd1);
  endtask

  task automatic load_finish(input int unsigned we_before);
    check("load_done", 32'(done), 32'd1);
    check("load_ready_off", 32'(s_ready), 32'd0);
    check("load_we_count", we_cnt - we_before, 32'd64);
    tick();
    check("load_done_once", 32'(done), 32'd0);
    check("load_idle", 32'(busy), 32'd0);
  endtask

  task automatic do_dump(input bit rnd, output int unsigned cycles, output int unsigned beats);
    int unsigned k, cyc, stall;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    k = 0;
    cyc = 0;
    stall = 0;
    while (done !== 1'b1 && cyc < 5000) begin
      if (rnd) begin
        if (m_valid && k == 5 && stall < 10) begin
          m_ready = 1'b0;
          check("stall_data", 32'(m_data), 32'h5);
          check("stall_valid", 32'(m_valid), 32'd1);
          stall++;
        end else begin
          m_ready = 1'($urandom_range(0, 1));
        end
      end else begin
        m_ready = 1'b1;
      end
      if (m_valid && m_ready && k < 64) begin
        cap[k] = m_data;
        k++;
      end
      tick();
      cyc++;
    end
    m_ready = 1'b0;
    cycles = cyc;
    beats = k;
    check("dump_budget", 32'(cyc < 5000), 32'd1);
    if (rnd) check("stall_len", stall, 32'd10);
    tick();
    check("dump_done_once", 32'(done), 32'd0);
    check("dump_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned cyc, beats, web;
    rst_n = 1'b0;
    load_start = 1'b0;
    dump_start = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    m_ready = 1'b0;
    repeat (3) tick();
    check("rst_outs", {26'd0, busy, done, s_ready, m_valid, ram_we, 1'b0}, 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    rst_n = 1'b1;
    tick();

    // Back-to-back load of 0..63, then a full-rate dump.
    web = we_cnt;
    do_load(20'h00000, 1, 64, 1'b0);
    load_finish(web);
    do_dump(1'b0, cyc, beats);
    check("dump_cycles", cyc, 32'd192);
    check("dump_beats", beats, 32'd64);
    check("dump_first", 32'(cap[0]), 32'h00000);
    check("dump_last", 32'(cap[63]), 32'h0003F);

    // Random backpressure with a 10-cycle stall on word 5.
    do_dump(1'b1, cyc, beats);
    check("rnd_beats", beats, 32'd64);
    check("rnd_word5", 32'(cap[5]), 32'h00005);
    check("rnd_word6", 32'(cap[6]), 32'h00006);

    // Both starts together: LOAD wins; dump_start mid-load ignored.
    web = we_cnt;
    do_load(20'h12340, 1, 64, 1'b1);
    load_finish(web);
    tick();
    check("no_late_dump", 32'(busy), 32'd0);

    // Reset after 10 words of a load.
    do_load(20'h55500, 1, 10, 1'b0);
    rst_n = 1'b0;
    tick();
    check("midrst_outs", {28'd0, busy, s_ready, ram_we, done}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("midrst_no_done", 32'(done), 32'd0);
    check("midrst_idle", 32'(busy), 32'd0);
    do_dump(1'b0, cyc, beats);
    check("midrst_w0", 32'(cap[0]), 32'h55500);
    check("midrst_w9", 32'(cap[9]), 32'h55509);
    check("midrst_w10", 32'(cap[10]), 32'h1234A);
    check("midrst_w63", 32'(cap[63]), 32'h1237F);

    // Sparse load, one valid in every three cycles.
    web = we_cnt;
    do_load(20'h0ABCD, 3, 64, 1'b0);
    load_finish(web);
    do_dump(1'b0, cyc, beats);
    check("gap_w0", 32'(cap[0]), 32'h0ABCD);
    check("gap_w63", 32'(cap[63]), 32'h0AC0C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_stream_loader.md
Name: bram_stream_loader

Overview:
- Port-side controller for a single-port, synchronous-read block RAM (default 64 x 20, write-then-read-old-data on the same address).
- LOAD mode: accepts a valid/ready word stream and writes it to consecutive RAM addresses starting at 0.
- DUMP mode: reads the RAM back from address 0 upward and presents each word on a valid/ready output stream.
- Sits between a host/config link and the RAM. Allows runtime reload and readback of RAM contents that otherwise come only from power-up initialisation.

Parameters:
- DATA_W, 20, RAM word width.
- ADDR_W, 6, RAM address width.
- DEPTH, 64, number of words loaded or dumped per operation; 1 <= DEPTH <= 2**ADDR_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- load_start  in  1  start LOAD; sampled in IDLE only.
- dump_start  in  1  start DUMP; sampled in IDLE only.
- s_valid  in  1  input stream word valid.
- s_data  in  DATA_W  input stream word.
- s_ready  out  1  input stream ready.
- m_valid  out  1  output stream word valid.
- m_data  out  DATA_W  output stream word.
- m_ready  in  1  output stream ready.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_di  out  DATA_W  RAM write data.
- ram_do  in  DATA_W  RAM read data, valid 1 cycle after its address.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when an operation completes.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values, applied on the clk edge with rst_n=0 regardless of state:
  - state=IDLE, addr counter=0.
  - s_ready=0, m_valid=0, m_data=0, done=0, busy=0.
  - ram_we=0, ram_addr=0.
- Reset mid-operation abandons the operation. Words already written stay in the RAM. No done pulse is produced.
- States: IDLE, LOAD, RD, CAP, HOLD, FIN.
- IDLE:
  - load_start=1 -> LOAD, addr=0.
  - else dump_start=1 -> RD, addr=0.
  - Both high at once: LOAD wins.
  - Start inputs are ignored in every state except IDLE.
- LOAD:
  - s_ready=1.
  - ram_we = s_valid (combinational). ram_di = s_data. ram_addr = addr.
  - Each accepted word (s_valid and s_ready) is written that cycle, then addr increments.
  - Accepting the word at addr=DEPTH-1 -> FIN. s_ready is 0 from the next cycle on.
  - s_valid gaps stall LOAD indefinitely; no timeout.
- RD: ram_we=0, ram_addr=addr. Next state is CAP.
- CAP:
  - m_data <= ram_do, m_valid <= 1.
  - Next state is HOLD.
  - ram_addr is held at addr.
- HOLD:
  - m_valid=1. m_data is stable until the handshake completes.
  - On m_ready=1 with addr=DEPTH-1 -> FIN, m_valid <= 0.
  - On m_ready=1 otherwise -> addr+1, RD, m_valid <= 0.
  - m_ready=0 holds the state indefinitely.
- Dump throughput: minimum 3 cycles per word (RD, CAP, HOLD).
- FIN: done=1 for exactly this one cycle, busy still 1. Next state is IDLE with addr=0.
- busy=1 from the cycle after a start is accepted through FIN inclusive.
- ram_we is 0 in every state except LOAD.
- s_ready is 0 in every state except LOAD.
- m_valid is 1 only in HOLD.
- Address arithmetic is ADDR_W bits. The counter never passes DEPTH-1, so it never wraps within an operation.
- DEPTH=1: LOAD completes after one accepted word; DUMP emits one word.

Test Plan:
- Reset, then load_start with 64 words 20'h00000..20'h0003F streamed back-to-back. Required: ram_we high for exactly 64 cycles at addr 0..63; done pulses 1 cycle after the last accept; s_ready=0 afterwards.
- Dump after that load with m_ready=1 constantly. Required: m_data sequence 20'h00000..20'h0003F; 3 cycles per word; 64 m_valid beats; single done pulse.
- Dump with m_ready toggling in a pseudo-random pattern, m_ready=0 for 10 cycles on word 5. Required: m_data holds 20'h00005 with m_valid=1 throughout the stall; no word is lost or duplicated.
- load_start and dump_start both asserted in IDLE. Required: LOAD is entered (s_ready=1). A dump_start pulse during LOAD has no effect.
- rst_n=0 for 1 cycle after 10 words of a LOAD. Required: next cycle busy=0, s_ready=0, ram_we=0, no done pulse. A following dump returns the new words at 0..9 and the prior contents at 10..63.
- LOAD with s_valid gaps (1 of every 3 cycles valid, data 20'h0ABCD+i). Required: writes occur only on valid cycles at consecutive addresses; completion after 64 accepts.
